operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
Front-end stage that assembles one FPU job from the 12-bit chip input pins. The host presents operand A, operand B and then the opcode, one word per strobe toggle. The block synchronizes the strobe, captures each word, and issues a one-cycle start pulse with stable num1/num2/op to the 10-bit FPU and result output stage. It holds the job until the downstream stage reports ready.

Parameters:
SYNC_STAGES, 2, number of flops in the strobe synchronizer chain (legal values 2..4).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
io_in  input  12  [11] host strobe (toggle), [10] abort flag, [9:0] data word
ready_in  input  1  downstream result stage can accept a new job
num1  output  10  operand A to FPU
num2  output  10  operand B to FPU
op  output  4  FPU operation select
start  output  1  one-cycle job-issue pulse
busy  output  1  job assembly or issue in progress
err  output  1  sticky overrun flag

Behaviour:
- Reset value is 0 for num1, num2, op, start and err, and for the synchronizer chain and strobe_prev. State resets to WAIT_A, so busy=0 after reset.
- Strobe path:
  - io_in[11] passes through SYNC_STAGES flops, then one more flop, strobe_prev.
  - event = sync_out XOR strobe_prev.
  - A toggle sampled at edge k produces event=1 during the cycle after edge k+SYNC_STAGES-1. The capture happens at edge k+SYNC_STAGES.
  - Each toggle produces exactly one event, whether 0->1 or 1->0.
- Host rule: io_in[10:0] must be stable from the toggle until SYNC_STAGES+2 cycles after it. The data bits are captured unsynchronized at the event edge.
- States: WAIT_A, WAIT_B, WAIT_OP, PEND.
- Abort (event with io_in[10]=1) has priority in every state, including PEND:
  - state goes to WAIT_A; err, num1, num2 and op clear to 0.
  - start is not asserted.
  - io_in[9:0] is ignored.
- WAIT_A: event with abort=0 sets num1 <= io_in[9:0] and moves to WAIT_B.
- WAIT_B: event sets num2 <= io_in[9:0] and moves to WAIT_OP.
- WAIT_OP: event sets op <= io_in[3:0] (io_in[9:4] ignored) and moves to PEND.
- PEND:
  - If ready_in=1 at an edge, start <= 1 for exactly one cycle and state goes to WAIT_A.
  - If ready_in=0, stay in PEND; num1, num2 and op are held.
  - A non-abort event in PEND sets err <= 1 and discards the word. The state and PEND are unchanged, and the issue still proceeds when ready_in rises.
  - If an overrun event and ready_in=1 fall on the same edge, both take effect: start pulses and err sets.
- start is registered and never high on two consecutive cycles. Minimum job spacing is 3 events plus 1 cycle.
- num1, num2 and op stay stable from the start pulse until the next capture of that same field. Downstream may sample them any time during or after the start cycle.
- busy = (state != WAIT_A). It is combinational from the state register.
- err is cleared only by reset or abort.
- Asynchronous reset mid-job:
  - Partial operands are lost and outputs return to reset values immediately.
  - strobe_prev resets to 0, so the first event after reset occurs only if the synchronized strobe is 1. Hosts must drive strobe=0 during reset.

Test Plan:
- Reset, then toggle strobe three times with ready_in=1, writing A=10'h2A5, B=10'h133, op=4'h3 -> one start pulse SYNC_STAGES+1 cycles after the third toggle; num1=2A5, num2=133, op=3; busy returns to 0 with the pulse; err=0.
- ready_in=0 when op is loaded and held for 20 cycles, then raised -> busy=1 and start=0 throughout; start pulses once on the edge after ready_in rises; operands unchanged throughout.
- In PEND, send a fourth non-abort toggle with data 10'h3FF -> err=1, num1/num2/op unchanged; after ready_in=1, start pulses once; err stays 1.
- After loading A and B, toggle with io_in[10]=1 -> state WAIT_A, outputs cleared, err=0, no start pulse; a following full sequence issues normally.
- Write op word 10'h3F9 -> op=4'h9, proving upper bits are ignored; strobe toggles both 0->1 and 1->0 each count as one event.
- Assert reset asynchronously mid-cycle during WAIT_OP -> all outputs are 0 immediately and busy=0; after release, with strobe held 0, no spurious event occurs.

Source files
------------

// File: rtl/operand_loader_if.sv
// Host-side bus of the operand loader: raw chip pins in, assembled FPU job out.
// The master modport is the host/downstream side; the slave modport is the loader.
interface operand_loader_if;
    logic [11:0] io_in;
    logic        ready_in;
    logic [9:0]  num1;
    logic [9:0]  num2;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic        err;

    modport master (
        output io_in, ready_in,
        input  num1, num2, op, start, busy, err
    );

    modport slave (
        input  io_in, ready_in,
        output num1, num2, op, start, busy, err
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles one FPU job (A, B, opcode) from toggle-strobed 12-bit pin words
// and issues it with a single-cycle start pulse once downstream is ready.
module operand_loader #(
    parameter int SYNC_STAGES = 2
) (
    input logic             clock,
    input logic             reset,
    operand_loader_if.slave bus
);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, PEND} state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   strobe_prev;
    logic                   strobe_evt;
    logic                   abort;
    logic [9:0]             word;
    state_t                 state;

    // Strobe synchronizer stage: edge detect on the synchronized toggle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain  <= '0;
            strobe_prev <= 1'b0;
        end else begin
            sync_chain  <= {sync_chain[SYNC_STAGES-2:0], bus.io_in[11]};
            strobe_prev <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign strobe_evt = sync_chain[SYNC_STAGES-1] ^ strobe_prev;
    // Data bits are held stable by the host, so they are sampled raw at the event edge
    assign abort      = bus.io_in[10];
    assign word       = bus.io_in[9:0];

    // Job assembly stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= WAIT_A;
            bus.num1  <= '0;
            bus.num2  <= '0;
            bus.op    <= '0;
            bus.start <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.start <= 1'b0;
            if (strobe_evt && abort) begin
                state    <= WAIT_A;
                bus.num1 <= '0;
                bus.num2 <= '0;
                bus.op   <= '0;
                bus.err  <= 1'b0;
            end else begin
                case (state)
                    WAIT_A: begin
                        if (strobe_evt) begin
                            bus.num1 <= word;
                            state    <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (strobe_evt) begin
                            bus.num2 <= word;
                            state    <= WAIT_OP;
                        end
                    end
                    WAIT_OP: begin
                        if (strobe_evt) begin
                            bus.op <= word[3:0];
                            state  <= PEND;
                        end
                    end
                    PEND: begin
                        // An overrun word is dropped but never blocks the pending issue
                        if (strobe_evt) begin
                            bus.err <= 1'b1;
                        end
                        if (bus.ready_in) begin
                            bus.start <= 1'b1;
                            state     <= WAIT_A;
                        end
                    end
                    default: state <= WAIT_A;
                endcase
            end
        end
    end

    assign bus.busy = (state != WAIT_A);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: a job-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_operand_loader;

    localparam int S = 2;

    logic clock;
    logic reset;
    operand_loader_if bus();

    operand_loader #(.SYNC_STAGES(S)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;
    int start_cnt = 0;
    logic strobe_val = 1'b0;

    // ---------------- behavioural model ----------------
    int unsigned cyc = 0;
    int unsigned ev_q[$];
    logic        last_strobe;
    int          words;
    int          old_words;
    logic        ev;
    logic [9:0]  m_num1, m_num2;
    logic [3:0]  m_op;
    logic        m_start, m_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_q.delete();
            last_strobe = 1'b0;
            words   = 0;
            m_num1  = '0;
            m_num2  = '0;
            m_op    = '0;
            m_start = 1'b0;
            m_err   = 1'b0;
        end else begin
            cyc++;
            ev = 1'b0;
            if (ev_q.size() > 0 && ev_q[0] == cyc) begin
                ev = 1'b1;
                void'(ev_q.pop_front());
            end
            // A toggle seen at this edge becomes an event S edges later
            if (bus.io_in[11] != last_strobe) ev_q.push_back(cyc + S);
            last_strobe = bus.io_in[11];
            m_start   = 1'b0;
            old_words = words;
            if (ev && bus.io_in[10]) begin
                words  = 0;
                m_num1 = '0;
                m_num2 = '0;
                m_op   = '0;
                m_err  = 1'b0;
            end else begin
                if (ev) begin
                    if (old_words == 0)      begin m_num1 = bus.io_in[9:0]; words = 1; end
                    else if (old_words == 1) begin m_num2 = bus.io_in[9:0]; words = 2; end
                    else if (old_words == 2) begin m_op = bus.io_in[3:0];   words = 3; end
                    else m_err = 1'b1;
                end
                if (old_words == 3 && bus.ready_in) begin
                    m_start = 1'b1;
                    words   = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        checks++;
        if ({bus.num1, bus.num2, bus.op, bus.start, bus.busy, bus.err} !==
            {m_num1, m_num2, m_op, m_start, (words != 0), m_err}) begin
            fails++;
            $display("FAIL model t=%0t actual n1=%h n2=%h op=%h st=%b bz=%b er=%b required n1=%h n2=%h op=%h st=%b bz=%b er=%b",
                     $time, bus.num1, bus.num2, bus.op, bus.start, bus.busy, bus.err,
                     m_num1, m_num2, m_op, m_start, (words != 0), m_err);
        end
    end

    always @(negedge clock) if (bus.start === 1'b1) start_cnt++;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic send(input logic [9:0] w, input logic ab);
        @(negedge clock);
        strobe_val = ~strobe_val;
        bus.io_in  = {strobe_val, ab, w};
        repeat (S + 3) @(negedge clock);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        bus.io_in = '0;
        bus.ready_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_num1", 16'(bus.num1), 16'h0);
        check("reset_op", 16'(bus.op), 16'h0);
        check("reset_busy_err_start", {13'b0, bus.busy, bus.err, bus.start}, 16'h0);

        // Basic job, ready already high
        bus.ready_in = 1'b1;
        send(10'h2A5, 1'b0);
        send(10'h133, 1'b0);
        @(negedge clock);
        strobe_val = ~strobe_val;
        bus.io_in  = {strobe_val, 1'b0, 10'h003};
        repeat (S + 1) @(negedge clock);
        #1;
        check("t1_pend_start_low", {15'b0, bus.start}, 16'h0);
        check("t1_pend_busy", {15'b0, bus.busy}, 16'h1);
        @(negedge clock);
        #1;
        check("t1_start_pulse", {15'b0, bus.start}, 16'h1);
        check("t1_busy_drop", {15'b0, bus.busy}, 16'h0);
        check("t1_num1", 16'(bus.num1), 16'h02A5);
        check("t1_num2", 16'(bus.num2), 16'h0133);
        check("t1_op", 16'(bus.op), 16'h0003);
        check("t1_err", {15'b0, bus.err}, 16'h0);
        @(negedge clock);
        #1;
        check("t1_start_one_cycle", {15'b0, bus.start}, 16'h0);
        check("t1_start_count", 16'(start_cnt), 16'd1);

        // Held in PEND with ready low
        bus.ready_in = 1'b0;
        send(10'h0F0, 1'b0);
        send(10'h10F, 1'b0);
        send(10'h005, 1'b0);
        repeat (20) @(negedge clock);
        #1;
        check("t2_busy_held", {15'b0, bus.busy}, 16'h1);
        check("t2_no_start", 16'(start_cnt), 16'd1);
        check("t2_num1_held", 16'(bus.num1), 16'h00F0);
        @(negedge clock);
        bus.ready_in = 1'b1;
        @(negedge clock);
        #1;
        check("t2_start", {15'b0, bus.start}, 16'h1);
        check("t2_op", 16'(bus.op), 16'h0005);
        check("t2_count", 16'(start_cnt), 16'd2);

        // Overrun in PEND
        bus.ready_in = 1'b0;
        send(10'h111, 1'b0);
        send(10'h222, 1'b0);
        send(10'h00C, 1'b0);
        send(10'h3FF, 1'b0);
        #1;
        check("t3_err_set", {15'b0, bus.err}, 16'h1);
        check("t3_num1_kept", 16'(bus.num1), 16'h0111);
        check("t3_num2_kept", 16'(bus.num2), 16'h0222);
        check("t3_op_kept", 16'(bus.op), 16'h000C);
        check("t3_no_start", 16'(start_cnt), 16'd2);
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("t3_issue_once", 16'(start_cnt), 16'd3);
        check("t3_err_sticky", {15'b0, bus.err}, 16'h1);

        // Abort after A and B
        bus.ready_in = 1'b0;
        send(10'h0AA, 1'b0);
        send(10'h0BB, 1'b0);
        send(10'h155, 1'b1);
        #1;
        check("t4_abort_busy", {15'b0, bus.busy}, 16'h0);
        check("t4_abort_err", {15'b0, bus.err}, 16'h0);
        check("t4_abort_num1", 16'(bus.num1), 16'h0);
        check("t4_abort_num2", 16'(bus.num2), 16'h0);
        check("t4_no_start", 16'(start_cnt), 16'd3);
        bus.ready_in = 1'b1;
        send(10'h011, 1'b0);
        send(10'h022, 1'b0);
        send(10'h3F9, 1'b0);
        #1;
        check("t5_op_low_bits", 16'(bus.op), 16'h0009);
        check("t5_num1", 16'(bus.num1), 16'h0011);
        check("t5_issued", 16'(start_cnt), 16'd4);

        // Asynchronous reset in WAIT_OP
        bus.ready_in = 1'b0;
        send(10'h0AB, 1'b0);
        send(10'h0CD, 1'b0);
        #1;
        check("t6_pre_busy", {15'b0, bus.busy}, 16'h1);
        base = start_cnt;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_num1", 16'(bus.num1), 16'h0);
        check("t6_rst_num2", 16'(bus.num2), 16'h0);
        check("t6_rst_flags", {13'b0, bus.busy, bus.err, bus.start}, 16'h0);
        strobe_val = 1'b0;
        bus.io_in  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        check("t6_no_spurious_busy", {15'b0, bus.busy}, 16'h0);
        check("t6_no_spurious_start", 16'(start_cnt), 16'(base));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
